inst_prefetch: RTL and testbench
================================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h80000000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, the queue entry count (power of two, 2..16).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  clock, all state on rising edge.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_flush  input  1  redirect; discards all queued and in-flight fetches.
REQ-007 i_flush_pc  input  32  redirect target; bits [1:0] ignored.
REQ-008 o_valid  output  1  queue head holds a valid instruction.
REQ-009 o_pc  output  32  address of head instruction.
REQ-010 o_inst  output  32  head instruction word.
REQ-011 i_ready  input  1  consumer pops head when o_valid && i_ready.
REQ-012 o_req  output  1  fetch request to instruction bus.
REQ-013 o_req_addr  output  32  word-aligned fetch address.
REQ-014 i_req_gnt  input  1  bus accepts request this cycle (meaningful only with o_req).
REQ-015 i_rsp_valid  input  1  response data valid; in order, >=1 cycle after grant, no backpressure.
REQ-016 i_rsp_data  input  32  response instruction word.

Function
REQ-017 SHALL keep fetch pointer fpc, response pointer rpc, queue count occ, in-flight count inf, discard count dsc.
REQ-018 SHALL drive o_req = !i_flush && (occ + inf + dsc < DEPTH); o_req_addr = fpc.
REQ-019 SHALL hold o_req_addr stable while o_req is high and i_req_gnt is low.
REQ-020 On o_req && i_req_gnt SHALL advance fpc by 4 (modulo 2^32) and increment inf.
REQ-021 On i_rsp_valid with dsc>0 SHALL drop the word and decrement dsc.
REQ-022 On i_rsp_valid with dsc=0 and inf>0 SHALL push {rpc, i_rsp_data}, advance rpc by 4, decrement inf.
REQ-023 i_rsp_valid with dsc=0 and inf=0 is a protocol violation; SHALL ignore it.
REQ-024 Pushed entries SHALL first appear at the head the cycle after the push (no bypass).
REQ-025 SHALL drive o_valid = (occ>0) && !i_flush; o_pc/o_inst from head entry.
REQ-026 Simultaneous push and pop SHALL leave occ unchanged; FIFO order preserved.
REQ-027 occ+inf+dsc SHALL never exceed DEPTH; push into a full queue cannot occur.
REQ-028 On i_flush SHALL set occ=0, fpc=rpc={i_flush_pc[31:2],2'b00}, inf=0, dsc = dsc + inf - (i_rsp_valid ? 1 : 0), clamped at 0.
REQ-029 A response arriving in the flush cycle SHALL be discarded; no grant can occur (o_req low).
REQ-030 Flush SHALL take priority over pop; pop in flush cycle has no effect.
REQ-031 New-stream requests MAY issue while dsc>0; in-order responses guarantee old words drain first.
REQ-032 Minimum redirect latency: flush at T, o_req at T+1, grant T+1, response T+2, o_valid T+3.

Reset
REQ-033 On i_rst (asynchronous) SHALL set fpc=rpc=RESET_VECTOR, occ=inf=dsc=0.
REQ-034 During reset o_valid=0, o_req=0; o_req rises the first cycle after i_rst deasserts.
REQ-035 Reset mid-operation SHALL abandon in-flight requests; stray later responses fall under REQ-023.

Verification
REQ-036 Reset release, gnt=1 always, rsp 1 cycle after gnt, ready=1 -> o_valid at cycle 3, o_pc 80000000, 80000004, 80000008 on consecutive cycles.
REQ-037 ready=0 from reset -> after 4 pushes o_req=0, occ=4; ready=1 -> pops 80000000.. in order, o_req reasserts, no gaps/duplicates.
REQ-038 Flush to 0x80000102 with inf=2 -> both old responses dropped, first o_pc=80000100, o_req_addr=80000100 next cycle.
REQ-039 Flush in the same cycle as a response with inf=1 -> response dropped, dsc=0, next pushed pc = flush target.
REQ-040 Flush to 0xFFFFFFFC -> o_req_addr sequence FFFFFFFC, 00000000, 00000004.
REQ-041 i_rst asserted mid-stream with occ=3 -> o_valid and o_req 0 same cycle; after release o_req_addr=80000000.

Source files
------------

// File: rtl/inst_prefetch_if.sv
// -----------------------------------------------------------------------------
// inst_prefetch_if
// Bundles every handshake/bus signal of the instruction prefetcher.
//   Redirect   : i_flush, i_flush_pc
//   Consumer   : o_valid, o_pc, o_inst, i_ready
//   Fetch bus  : o_req, o_req_addr, i_req_gnt, i_rsp_valid, i_rsp_data
// Signal names are written from the prefetcher's point of view (i_ = into the
// prefetcher, o_ = out of it).
// Modports:
//   master : the prefetcher itself
//   slave  : the environment (consumer, redirect source and instruction bus)
// -----------------------------------------------------------------------------
interface inst_prefetch_if;
  logic        i_flush;
  logic [31:0] i_flush_pc;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        i_ready;
  logic        o_req;
  logic [31:0] o_req_addr;
  logic        i_req_gnt;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;

  modport master (
    input  i_flush, i_flush_pc, i_ready, i_req_gnt, i_rsp_valid, i_rsp_data,
    output o_valid, o_pc, o_inst, o_req, o_req_addr
  );

  modport slave (
    output i_flush, i_flush_pc, i_ready, i_req_gnt, i_rsp_valid, i_rsp_data,
    input  o_valid, o_pc, o_inst, o_req, o_req_addr
  );
endinterface

// File: rtl/inst_prefetch.sv
// -----------------------------------------------------------------------------
// inst_prefetch
// Sequential instruction prefetcher with a DEPTH-entry {pc, inst} queue.
// Issues word-aligned fetches while queued + in-flight + to-be-discarded words
// fit in the queue, stores in-order responses, and presents the oldest entry to
// the consumer. A flush redirects the stream; responses belonging to fetches
// issued before the flush are counted in a discard counter and dropped on
// arrival, so new-stream fetches can start immediately.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : inst_prefetch_if.master (redirect, consumer and fetch-bus signals)
// Parameters:
//   RESET_VECTOR : first fetch address after reset
//   DEPTH        : queue entries, power of two in 2..16
// -----------------------------------------------------------------------------
module inst_prefetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter int unsigned DEPTH        = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  inst_prefetch_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  // Architectural state
  logic [31:0] fpc_q, fpc_d;   // next address to request
  logic [31:0] rpc_q, rpc_d;   // address of the next response to be kept
  cnt_t        occ_q, occ_d;   // queued entries
  cnt_t        inf_q, inf_d;   // granted, response still pending, to be kept
  cnt_t        dsc_q, dsc_d;   // granted before a flush, response to be dropped
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];

  logic [CW+1:0] sum_s;
  logic          req_s;
  logic          gnt_s;
  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  cnt_t          pend_s;
  logic [31:0]   flush_tgt_s;
  logic          unused_s;

  // The two low redirect bits are ignored by design.
  assign unused_s    = ^bus.i_flush_pc[1:0];
  assign flush_tgt_s = {bus.i_flush_pc[31:2], 2'b00};

  // Handshake decode; outputs are masked during reset and in the flush cycle.
  always_comb begin
    sum_s   = {2'b00, occ_q} + {2'b00, inf_q} + {2'b00, dsc_q};
    req_s   = 1'b0;
    valid_s = 1'b0;
    if (!i_rst && !bus.i_flush) begin
      req_s   = (sum_s < DEPTH_W);
      valid_s = (occ_q != cnt_t'(0));
    end else begin
      req_s   = 1'b0;
      valid_s = 1'b0;
    end
    gnt_s  = req_s && bus.i_req_gnt;
    pop_s  = valid_s && bus.i_ready;
    drop_s = bus.i_rsp_valid && (dsc_q != cnt_t'(0));
    // A response with nothing outstanding is a protocol violation and ignored.
    push_s = bus.i_rsp_valid && (dsc_q == cnt_t'(0)) && (inf_q != cnt_t'(0))
             && !bus.i_flush;
  end

  // Next-state logic; flush overrides grant, push and pop.
  always_comb begin
    fpc_d    = fpc_q;
    rpc_d    = rpc_q;
    occ_d    = occ_q;
    inf_d    = inf_q;
    dsc_d    = dsc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pend_s   = dsc_q + inf_q;
    if (bus.i_flush) begin
      fpc_d    = flush_tgt_s;
      rpc_d    = flush_tgt_s;
      occ_d    = cnt_t'(0);
      inf_d    = cnt_t'(0);
      rd_ptr_d = ptr_t'(0);
      wr_ptr_d = ptr_t'(0);
      // Every outstanding old fetch becomes a discard, minus the response
      // that is being dropped right now.
      if (bus.i_rsp_valid && (pend_s != cnt_t'(0))) begin
        dsc_d = pend_s - cnt_t'(1);
      end else begin
        dsc_d = pend_s;
      end
    end else begin
      if (gnt_s) begin
        fpc_d = fpc_q + 32'd4;
      end else begin
        fpc_d = fpc_q;
      end
      if (drop_s) begin
        dsc_d = dsc_q - cnt_t'(1);
      end else begin
        dsc_d = dsc_q;
      end
      if (push_s) begin
        rpc_d    = rpc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end else begin
        rpc_d    = rpc_q;
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      inf_d = inf_q + cnt_t'(gnt_s) - cnt_t'(push_s);
      occ_d = occ_q + cnt_t'(push_s) - cnt_t'(pop_s);
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fpc_q    <= RESET_VECTOR;
      rpc_q    <= RESET_VECTOR;
      occ_q    <= cnt_t'(0);
      inf_q    <= cnt_t'(0);
      dsc_q    <= cnt_t'(0);
      rd_ptr_q <= ptr_t'(0);
      wr_ptr_q <= ptr_t'(0);
    end else begin
      fpc_q    <= fpc_d;
      rpc_q    <= rpc_d;
      occ_q    <= occ_d;
      inf_q    <= inf_d;
      dsc_q    <= dsc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Queue storage; contents are qualified by occ, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      pc_mem_q[wr_ptr_q]   <= rpc_q;
      inst_mem_q[wr_ptr_q] <= bus.i_rsp_data;
    end
  end

  // Entries are read from storage, so a push becomes visible one cycle later.
  assign bus.o_valid    = valid_s;
  assign bus.o_pc       = pc_mem_q[rd_ptr_q];
  assign bus.o_inst     = inst_mem_q[rd_ptr_q];
  assign bus.o_req      = req_s;
  assign bus.o_req_addr = fpc_q;

endmodule

// File: tb/tb_inst_prefetch.sv
// -----------------------------------------------------------------------------
// tb_inst_prefetch
// Self-checking bench for inst_prefetch: directed vector tables with constant
// expectations, hand-written reset/protocol sequences, and a randomised run.
// A bus model returns in-order responses with configurable latency and a
// scoreboard tracks granted and queued words to predict every output.
// -----------------------------------------------------------------------------
module tb_inst_prefetch;
  localparam logic [31:0] RV    = 32'h8000_0000;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_prefetch_if bus ();

  inst_prefetch #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } pend_t;

  typedef struct {
    bit          rst;
    int          lat;
    bit          gnt;
    bit          rdy;
    bit          fl;
    logic [31:0] fpc;
    bit          ev;
    logic [31:0] epc;
    bit          er;
    logic [31:0] eaddr;
  } vec_t;

  pend_t       pend_q[$];
  logic [31:0] vis_q[$];
  vec_t        tbl[$];
  logic [31:0] exp_fpc;
  int          rsp_lat  = 1;
  int          last_due = 0;
  int          cyc      = 0;
  int          n_vec    = 0;
  int          n_err    = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive_idle();
    bus.i_flush     = 1'b0;
    bus.i_flush_pc  = 32'h0;
    bus.i_ready     = 1'b0;
    bus.i_req_gnt   = 1'b0;
    bus.i_rsp_valid = 1'b0;
    bus.i_rsp_data  = 32'h0;
  endtask

  task automatic model_reset(input int lat);
    pend_q.delete();
    vis_q.delete();
    exp_fpc  = RV;
    last_due = cyc;
    rsp_lat  = lat;
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    #1;
    chk1("reset o_valid", bus.o_valid, 1'b0);
    chk1("reset o_req", bus.o_req, 1'b0);
    model_reset(lat);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, let the bus model respond, compare
  // outputs against the scoreboard, then apply this cycle's edge effects.
  task automatic step(input bit gnt, input bit rdy, input bit fl,
                      input logic [31:0] fpc_in, input bit inj);
    bit    rsp;
    bit    exp_v;
    bit    exp_r;
    int    due;
    pend_t p;
    @(negedge clk);
    bus.i_req_gnt  = gnt;
    bus.i_ready    = rdy;
    bus.i_flush    = fl;
    bus.i_flush_pc = fpc_in;
    rsp = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    if (rsp) begin
      bus.i_rsp_valid = 1'b1;
      bus.i_rsp_data  = inst_of(pend_q[0].addr);
    end else if (inj) begin
      bus.i_rsp_valid = 1'b1;
      bus.i_rsp_data  = 32'hDEAD_BEEF;
    end else begin
      bus.i_rsp_valid = 1'b0;
      bus.i_rsp_data  = 32'h0;
    end
    #1;
    exp_v = !fl && (vis_q.size() > 0);
    exp_r = !fl && ((pend_q.size() + vis_q.size()) < DEPTH);
    chk1("o_valid", bus.o_valid, exp_v);
    if (exp_v && bus.o_valid) begin
      chk32("o_pc", bus.o_pc, vis_q[0]);
      chk32("o_inst", bus.o_inst, inst_of(vis_q[0]));
    end
    chk1("o_req", bus.o_req, exp_r);
    if (exp_r && bus.o_req) chk32("o_req_addr", bus.o_req_addr, exp_fpc);
    if (exp_v && rdy) void'(vis_q.pop_front());
    if (rsp) begin
      p = pend_q.pop_front();
      if (!p.stale && !fl) vis_q.push_back(p.addr);
    end
    if (exp_r && gnt) begin
      due = cyc + rsp_lat;
      if (due <= last_due) due = last_due + 1;
      p.addr  = exp_fpc;
      p.stale = 1'b0;
      p.due   = due;
      pend_q.push_back(p);
      last_due = due;
      exp_fpc  = exp_fpc + 32'd4;
    end
    if (fl) begin
      vis_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_fpc = {fpc_in[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic add(input bit r, input int lat, input bit gnt, input bit rdy,
                     input bit fl, input logic [31:0] fpc, input bit ev,
                     input logic [31:0] epc, input bit er, input logic [31:0] eaddr);
    vec_t v;
    v.rst = r;   v.lat = lat; v.gnt = gnt; v.rdy = rdy; v.fl = fl;
    v.fpc = fpc; v.ev  = ev;  v.epc = epc; v.er  = er;  v.eaddr = eaddr;
    tbl.push_back(v);
  endtask

  initial begin
    drive_idle();
    exp_fpc = RV;

    // Streaming from reset: o_valid on the third cycle, consecutive pcs.
    add(1, 1, 1, 1, 0, 32'h0, 0, 32'h0,         1, 32'h8000_0000);
    add(0, 1, 1, 1, 0, 32'h0, 0, 32'h0,         1, 32'h8000_0004);
    add(0, 1, 1, 1, 0, 32'h0, 1, 32'h8000_0000, 1, 32'h8000_0008);
    add(0, 1, 1, 1, 0, 32'h0, 1, 32'h8000_0004, 1, 32'h8000_000C);
    add(0, 1, 1, 1, 0, 32'h0, 1, 32'h8000_0008, 1, 32'h8000_0010);
    // Consumer stalled: queue fills, o_req drops, then drains in order.
    add(1, 1, 1, 0, 0, 32'h0, 0, 32'h0,         1, 32'h8000_0000);
    add(0, 1, 1, 0, 0, 32'h0, 0, 32'h0,         1, 32'h8000_0004);
    add(0, 1, 1, 0, 0, 32'h0, 1, 32'h8000_0000, 1, 32'h8000_0008);
    add(0, 1, 1, 0, 0, 32'h0, 1, 32'h8000_0000, 1, 32'h8000_000C);
    add(0, 1, 1, 0, 0, 32'h0, 1, 32'h8000_0000, 0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0, 1, 32'h8000_0000, 0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0, 1, 32'h8000_0000, 0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0, 1, 32'h8000_0004, 1, 32'h8000_0010);
    add(0, 1, 1, 1, 0, 32'h0, 1, 32'h8000_0008, 1, 32'h8000_0014);
    add(0, 1, 1, 1, 0, 32'h0, 1, 32'h8000_000C, 1, 32'h8000_0018);
    add(0, 1, 1, 1, 0, 32'h0, 1, 32'h8000_0010, 1, 32'h8000_001C);
    // Flush with two fetches in flight (latency 2): both old words dropped.
    add(1, 2, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0000);
    add(0, 2, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0004);
    add(0, 2, 1, 1, 1, 32'h8000_0102, 0, 32'h0,         0, 32'h0);
    add(0, 2, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0100);
    add(0, 2, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0104);
    add(0, 2, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0108);
    add(0, 2, 1, 1, 0, 32'h0,         1, 32'h8000_0100, 1, 32'h8000_010C);
    add(0, 2, 1, 1, 0, 32'h0,         1, 32'h8000_0104, 1, 32'h8000_0110);
    // Flush coinciding with the only in-flight response.
    add(1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0000);
    add(0, 1, 0, 1, 1, 32'h0000_1000, 0, 32'h0,         0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_1000);
    add(0, 1, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_1004);
    add(0, 1, 1, 1, 0, 32'h0,         1, 32'h0000_1000, 1, 32'h0000_1008);
    // Flush near the top of the address space: fetch address wraps.
    add(1, 1, 0, 1, 1, 32'hFFFF_FFFF, 0, 32'h0,         0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC);
    add(0, 1, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0000);
    add(0, 1, 1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h0000_0004);
    add(0, 1, 1, 1, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h0000_0008);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(tbl[i].lat);
      step(tbl[i].gnt, tbl[i].rdy, tbl[i].fl, tbl[i].fpc, 1'b0);
      chk1($sformatf("vec%0d o_valid", i), bus.o_valid, tbl[i].ev);
      if (tbl[i].ev) chk32($sformatf("vec%0d o_pc", i), bus.o_pc, tbl[i].epc);
      chk1($sformatf("vec%0d o_req", i), bus.o_req, tbl[i].er);
      if (tbl[i].er) chk32($sformatf("vec%0d o_req_addr", i), bus.o_req_addr, tbl[i].eaddr);
    end

    // Reset asserted mid-stream with three queued entries.
    do_reset(1);
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    bus.i_req_gnt   = 1'b0;
    bus.i_rsp_valid = 1'b0;
    #1;
    chk1("midrst pre o_valid", bus.o_valid, 1'b1);
    chk32("midrst pre o_pc", bus.o_pc, RV);
    rst = 1'b1;
    #1;
    chk1("midrst o_valid", bus.o_valid, 1'b0);
    chk1("midrst o_req", bus.o_req, 1'b0);
    model_reset(1);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Stray response with nothing outstanding must be ignored.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk32("after rst o_req_addr", bus.o_req_addr, RV);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk1("stray rsp o_valid", bus.o_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk32("stray rsp o_req_addr", bus.o_req_addr, RV);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk1("stray rsp first o_valid", bus.o_valid, 1'b1);
    chk32("stray rsp first o_pc", bus.o_pc, RV);

    // Randomised traffic with variable latency and occasional redirects.
    do_reset(2);
    for (int k = 0; k < 600; k++) begin
      rsp_lat = int'($urandom_range(1, 3));
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 4, $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
